// File: rtl/flash_arb_pkg.sv
// rtl/flash_arb_pkg.sv - shared types and safe pad constants for the flash pad arbiter
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    GUARD = 2'd3
  } flash_arb_state_t;

  typedef logic flash_arb_id_t;

  localparam logic       FLASH_SAFE_CSB    = 1'b1;
  localparam logic       FLASH_SAFE_CLK    = 1'b0;
  localparam logic [1:0] FLASH_SAFE_IO_OE  = 2'b00;
  localparam logic [1:0] FLASH_SAFE_IO_IE  = 2'b11;
  localparam logic [1:0] FLASH_SAFE_IO_OUT = 2'b00;

  // Only meaningful when at least one request is high; a tie goes to the one that did not own last.
  function automatic flash_arb_id_t flash_arb_pick(input logic r0, input logic r1,
                                                   input flash_arb_id_t last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

endpackage

// File: rtl/flash_arb_timer.sv
// rtl/flash_arb_timer.sv - loadable saturating down-counter shared by guard and timeout
module flash_arb_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/flash_pad_arbiter.sv
// rtl/flash_pad_arbiter.sv - two-master SPI flash pad arbiter with guard interval
// Optional forced revoke under contention: define FLASH_ARB_TIMEOUT_EN.
module flash_pad_arbiter
  import flash_arb_pkg::*;
#(
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       r0_req,
  output logic       r0_gnt,
  input  logic       r0_csb,
  input  logic       r0_sclk,
  input  logic       r0_csb_oe,
  input  logic       r0_sclk_oe,
  input  logic [1:0] r0_io_do,
  input  logic [1:0] r0_io_oe,
  input  logic [1:0] r0_io_ie,
  output logic [1:0] r0_io_di,
  input  logic       r1_req,
  output logic       r1_gnt,
  input  logic       r1_csb,
  input  logic       r1_sclk,
  input  logic       r1_csb_oe,
  input  logic       r1_sclk_oe,
  input  logic [1:0] r1_io_do,
  input  logic [1:0] r1_io_oe,
  input  logic [1:0] r1_io_ie,
  output logic [1:0] r1_io_di,
  output logic       pad_csb_out,
  output logic       pad_csb_oe,
  output logic       pad_clk_out,
  output logic       pad_clk_oe,
  output logic [1:0] pad_io_out,
  output logic [1:0] pad_io_oe,
  output logic [1:0] pad_io_ie,
  input  logic [1:0] pad_io_in,
  output logic       timeout_evt
);

  localparam int MAX_CYCLES = (GUARD_CYCLES > TIMEOUT_CYCLES) ? GUARD_CYCLES : TIMEOUT_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  flash_arb_state_t state_q, state_d;
  flash_arb_id_t    last_q, last_d, cur, pick_id;
  logic             r0_gnt_q, r0_gnt_d, r1_gnt_q, r1_gnt_d;
  logic             own_req, own_csb;
  logic             tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]    tmr_val;

  assign cur     = (state_q == OWN1);
  assign own_req = cur ? r1_req : r0_req;
  assign own_csb = cur ? r1_csb : r0_csb;
  assign pick_id = flash_arb_pick(r0_req, r1_req, last_q);

`ifdef FLASH_ARB_TIMEOUT_EN
  logic oth_req, evt_d, timeout_evt_q;
  assign oth_req = cur ? r0_req : r1_req;
`endif

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = TW'(GUARD_CYCLES - 1);
`ifdef FLASH_ARB_TIMEOUT_EN
    evt_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (r0_req || r1_req) state_d = pick_id ? OWN1 : OWN0;
      end
      OWN0, OWN1: begin
        if (!own_req && own_csb) begin
          state_d  = GUARD;
          last_d   = cur;
          tmr_load = 1'b1;
        end
`ifdef FLASH_ARB_TIMEOUT_EN
        // Timer holds TIMEOUT-k during the k-th contended cycle and saturates at zero.
        else if (oth_req && tmr_done && own_csb) begin
          state_d  = GUARD;
          last_d   = cur;
          tmr_load = 1'b1;
          evt_d    = 1'b1;
        end else if (!oth_req) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(TIMEOUT_CYCLES - 1);
        end else begin
          tmr_en = 1'b1;
        end
`endif
      end
      GUARD: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          if (r0_req || r1_req) state_d = pick_id ? OWN1 : OWN0;
          else                  state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FLASH_ARB_TIMEOUT_EN
    if ((state_d == OWN0 || state_d == OWN1) && (state_d != state_q)) begin
      tmr_load = 1'b1;
      tmr_val  = TW'(TIMEOUT_CYCLES - 1);
    end
`endif
    r0_gnt_d = (state_d == OWN0);
    r1_gnt_d = (state_d == OWN1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      r0_gnt_q <= 1'b0;
      r1_gnt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      r0_gnt_q <= r0_gnt_d;
      r1_gnt_q <= r1_gnt_d;
    end
  end

`ifdef FLASH_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_evt_q <= 1'b0;
    else        timeout_evt_q <= evt_d;
  end
  assign timeout_evt = timeout_evt_q;
`else
  assign timeout_evt = 1'b0;
`endif

  assign r0_gnt = r0_gnt_q;
  assign r1_gnt = r1_gnt_q;

  flash_arb_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  // Pads follow the registered state so a reset deselects the flash without waiting for a clock.
  always_comb begin
    pad_csb_out = FLASH_SAFE_CSB;
    pad_csb_oe  = 1'b1;
    pad_clk_out = FLASH_SAFE_CLK;
    pad_clk_oe  = 1'b1;
    pad_io_out  = FLASH_SAFE_IO_OUT;
    pad_io_oe   = FLASH_SAFE_IO_OE;
    pad_io_ie   = FLASH_SAFE_IO_IE;
    r0_io_di    = 2'b00;
    r1_io_di    = 2'b00;
    case (state_q)
      OWN0: begin
        pad_csb_out = r0_csb;
        pad_csb_oe  = r0_csb_oe;
        pad_clk_out = r0_sclk;
        pad_clk_oe  = r0_sclk_oe;
        pad_io_out  = r0_io_do;
        pad_io_oe   = r0_io_oe;
        pad_io_ie   = r0_io_ie;
        r0_io_di    = pad_io_in;
      end
      OWN1: begin
        pad_csb_out = r1_csb;
        pad_csb_oe  = r1_csb_oe;
        pad_clk_out = r1_sclk;
        pad_clk_oe  = r1_sclk_oe;
        pad_io_out  = r1_io_do;
        pad_io_oe   = r1_io_oe;
        pad_io_ie   = r1_io_ie;
        r1_io_di    = pad_io_in;
      end
      default: ;
    endcase
  end

endmodule
